// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
//
// Serial transmit engine of the UART. Pops one character at a time from the
// TX FIFO, frames it (start bit, 5..8 data bits LSB first, optional even/odd
// parity, one or two stop bits) and drives the TXD line. Every state change,
// TXD update and FIFO pop happens only on a PCLK edge where baud_tick is high.
//
// Optional feature macro: UART_TX_BREAK_EN
//   Defined   -> adds the tx_break input and a BREAK state that holds TXD low
//                for as long as tx_break is high, then sends one stop bit of
//                mark before returning to IDLE.
//   Undefined -> no tx_break port, no BREAK state.
//
// Ports
//   PCLK                 in   system clock, rising edge
//   PRESET               in   synchronous active-high reset
//   baud_tick            in   one-PCLK enable per bit time
//   TXen                 in   transmit enable; gates new pops only
//   parity_bit_mode      in   1 = insert a parity bit
//   parity_odd           in   1 = odd parity, 0 = even parity
//   stop_bit_twice       in   1 = two stop bits
//   number_data_transmit in   data bits per character (clamped to 5..8)
//   tx_fifo_empty        in   TX FIFO empty flag
//   tx_fifo_data         in   TX FIFO head word (first-word-fall-through)
//   tx_break             in   break request (UART_TX_BREAK_EN only)
//   tx_fifo_pop          out  one-cycle pop strobe to the TX FIFO
//   TXD                  out  registered serial line, idle high
//   tx_busy              out  high whenever the FSM is not in IDLE
//   tx_done              out  one-cycle pulse on the tick that ends a frame
// -----------------------------------------------------------------------------
module uart_tx_fsm (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       baud_tick,
    input  logic       TXen,
    input  logic       parity_bit_mode,
    input  logic       parity_odd,
    input  logic       stop_bit_twice,
    input  logic [3:0] number_data_transmit,
    input  logic       tx_fifo_empty,
    input  logic [7:0] tx_fifo_data,
`ifdef UART_TX_BREAK_EN
    input  logic       tx_break,
`endif
    output logic       tx_fifo_pop,
    output logic       TXD,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP_0 = 3'd4,
        S_STOP_1 = 3'd5
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK  = 3'd6
`endif
    } state_t;

    state_t     state;
    logic [7:0] shift_reg;   // remaining data bits, LSB is the next to send
    logic [2:0] bit_cnt;     // index of the data bit currently on the line
    logic [2:0] last_idx;    // index of the last data bit of this frame
    logic       par_en_l;    // latched parity_bit_mode
    logic       par_bit_l;   // parity bit precomputed at the latch
    logic       stop2_l;     // latched stop_bit_twice

    logic brk_req;           // break request seen in IDLE
    logic brk_stop;          // current STOP_0 is the mark after a break

`ifdef UART_TX_BREAK_EN
    logic brk_mark;          // set while the post-break stop bit is on the line
    assign brk_req  = tx_break;
    assign brk_stop = brk_mark;
`else
    assign brk_req  = 1'b0;
    assign brk_stop = 1'b0;
`endif

    // Clamp the requested character length to 5..8 and return the index of
    // the last data bit (4..7), which is what the data counter compares to.
    function automatic logic [2:0] clamp_last(input logic [3:0] n);
        logic [2:0] r;
        if (n < 4'd5) begin
            r = 3'd4;
        end else if (n > 4'd8) begin
            r = 3'd7;
        end else begin
            r = n[2:0] - 3'd1;   // n = 8 wraps n[2:0] to 0, giving 7
        end
        return r;
    endfunction

    // Parity over the data bits that will actually be sent; bits above the
    // character length do not contribute.
    function automatic logic calc_parity(input logic [7:0] d,
                                         input logic [2:0] last,
                                         input logic       odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i <= int'(last)) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

    // FIFO handshake: the FIFO presents its head word on tx_fifo_data whenever
    // tx_fifo_empty is low (valid = ~tx_fifo_empty). tx_fifo_pop acts as the
    // ready/accept strobe: the word is consumed on the PCLK edge where
    // tx_fifo_pop is high, and the FSM latches tx_fifo_data on that same edge.
    // A pop is only offered on a baud tick, in IDLE or at the end of a frame.
    logic can_pop;
    logic frame_end;
    logic idle_pop;

    assign can_pop   = baud_tick & ~PRESET & TXen & ~tx_fifo_empty;

    // Leaving the last stop bit of a real character (not the mark that
    // follows a break).
    assign frame_end = baud_tick & ~PRESET &
                       (((state == S_STOP_0) & ~stop2_l & ~brk_stop) |
                        (state == S_STOP_1));

    // A pending break wins over a pop in IDLE.
    assign idle_pop  = (state == S_IDLE) & can_pop & ~brk_req;

    assign tx_fifo_pop = idle_pop | (frame_end & can_pop);
    assign tx_done     = frame_end;
    assign tx_busy     = (state != S_IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= S_IDLE;
            TXD       <= 1'b1;
            shift_reg <= 8'd0;
            bit_cnt   <= 3'd0;
            last_idx  <= 3'd0;
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
            stop2_l   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_mark  <= 1'b0;
`endif
        end else if (baud_tick) begin
            if (tx_fifo_pop) begin
                // New character: latch data and the whole frame setup, so
                // configuration changes mid-frame have no effect.
                shift_reg <= tx_fifo_data;
                bit_cnt   <= 3'd0;
                last_idx  <= clamp_last(number_data_transmit);
                par_en_l  <= parity_bit_mode;
                par_bit_l <= calc_parity(tx_fifo_data,
                                         clamp_last(number_data_transmit),
                                         parity_odd);
                stop2_l   <= stop_bit_twice;
                state     <= S_START;
                TXD       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        TXD <= 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (tx_break) begin
                            state <= S_BREAK;
                            TXD   <= 1'b0;
                        end
`endif
                    end

                    S_START: begin
                        TXD       <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= 3'd0;
                        state     <= S_DATA;
                    end

                    S_DATA: begin
                        if (bit_cnt == last_idx) begin
                            if (par_en_l) begin
                                state <= S_PARITY;
                                TXD   <= par_bit_l;
                            end else begin
                                state <= S_STOP_0;
                                TXD   <= 1'b1;
                            end
                        end else begin
                            TXD       <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end

                    S_PARITY: begin
                        state <= S_STOP_0;
                        TXD   <= 1'b1;
                    end

                    S_STOP_0: begin
                        TXD <= 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (brk_mark) begin
                            brk_mark <= 1'b0;
                            state    <= S_IDLE;
                        end else
`endif
                        if (stop2_l) begin
                            state <= S_STOP_1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end

                    S_STOP_1: begin
                        TXD   <= 1'b1;
                        state <= S_IDLE;
                    end

`ifdef UART_TX_BREAK_EN
                    S_BREAK: begin
                        if (tx_break) begin
                            TXD <= 1'b0;
                        end else begin
                            // Release: one stop bit of mark, then IDLE.
                            TXD      <= 1'b1;
                            brk_mark <= 1'b1;
                            state    <= S_STOP_0;
                        end
                    end
`endif

                    default: begin
                        TXD   <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fsm
//
// Bench for uart_tx_fsm. A small FIFO model feeds characters; for every
// character pushed, the expected frame (bit string, first bit in bit 0) and
// its length are pushed to the scoreboard. A monitor rebuilds each frame from
// TXD sampled on baud ticks between a pop and tx_done and compares it with the
// front of the scoreboard.
// -----------------------------------------------------------------------------
module tb_uart_tx_fsm;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       baud_tick;
    logic       TXen;
    logic       parity_bit_mode;
    logic       parity_odd;
    logic       stop_bit_twice;
    logic [3:0] number_data_transmit;
    logic       tx_fifo_empty;
    logic [7:0] tx_fifo_data;
`ifdef UART_TX_BREAK_EN
    logic       tx_break;
`endif
    logic       tx_fifo_pop;
    logic       TXD;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          exp_len_q[$];
    logic [7:0]  fifo_q[$];

    int   div = 0;
    logic s_tick, s_txd, s_pop, s_done;

    // ---------------- clock and DUT ----------------
    always #5 PCLK = ~PCLK;

    uart_tx_fsm dut (
        .PCLK                 (PCLK),
        .PRESET               (PRESET),
        .baud_tick            (baud_tick),
        .TXen                 (TXen),
        .parity_bit_mode      (parity_bit_mode),
        .parity_odd           (parity_odd),
        .stop_bit_twice       (stop_bit_twice),
        .number_data_transmit (number_data_transmit),
        .tx_fifo_empty        (tx_fifo_empty),
        .tx_fifo_data         (tx_fifo_data),
`ifdef UART_TX_BREAK_EN
        .tx_break             (tx_break),
`endif
        .tx_fifo_pop          (tx_fifo_pop),
        .TXD                  (TXD),
        .tx_busy              (tx_busy),
        .tx_done              (tx_done)
    );

    initial begin
        #800000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected frame: start 0, N data bits LSB first, optional parity, stops.
    function automatic logic [15:0] frame_model(input logic [7:0] d, input int nb,
                                                input bit pen, input bit odd,
                                                input bit s2, output int len);
        logic [15:0] f;
        int n;
        int pos;
        logic p;
        f = 16'd0;
        n = (nb < 5) ? 5 : ((nb > 8) ? 8 : nb);
        pos = 1;
        p = odd;
        for (int i = 0; i < n; i++) begin
            f[pos] = d[i];
            p = p ^ d[i];
            pos++;
        end
        if (pen) begin
            f[pos] = p;
            pos++;
        end
        f[pos] = 1'b1;
        pos++;
        if (s2) begin
            f[pos] = 1'b1;
            pos++;
        end
        len = pos;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic update_fifo_pins();
        tx_fifo_empty = (fifo_q.size() == 0);
        tx_fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    // One PCLK: sample at negedge, apply FIFO pop and new inputs #1 after posedge.
    task automatic cycle();
        @(negedge PCLK);
        s_tick = baud_tick;
        s_txd  = TXD;
        s_pop  = tx_fifo_pop;
        s_done = tx_done;
        @(posedge PCLK);
        #1;
        if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        update_fifo_pins();
        div = (div + 1) % 16;
        baud_tick = (div == 0);
    endtask

    task automatic set_cfg(input int nb, input bit pen, input bit odd, input bit s2);
        number_data_transmit = nb[3:0];
        parity_bit_mode      = pen;
        parity_odd           = odd;
        stop_bit_twice       = s2;
    endtask

    task automatic push_byte(input logic [7:0] d);
        int len;
        logic [15:0] f;
        f = frame_model(d, int'(number_data_transmit), parity_bit_mode,
                        parity_odd, stop_bit_twice, len);
        fifo_q.push_back(d);
        exp_q.push_back(f);
        exp_len_q.push_back(len);
        update_fifo_pins();
    endtask

    task automatic run_idle(input int max_cycles);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!(fifo_q.size() == 0 && !tx_busy) && k < max_cycles);
        if (k >= max_cycles) check("run_idle_timeout", 1, 0);
    endtask

    task automatic wait_busy(input int max_cycles);
        int k;
        k = 0;
        while (!tx_busy && k < max_cycles) begin
            cycle();
            k++;
        end
        if (k >= max_cycles) check("wait_busy_timeout", 1, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] cap_bits = 16'd0;
    int          cap_len = 0;
    bit          cap_on = 1'b0;
    int          busy_err = 0;
    logic        prev_txd = 1'b1;
    bit          prev_tick = 1'b0;
    bit          prev_rst = 1'b1;

    always @(negedge PCLK) begin
        if (!prev_tick && !prev_rst) check("txd_hold", TXD, prev_txd);
        if (!baud_tick) check("strobe_no_tick", {tx_fifo_pop, tx_done}, 2'b00);
        if (PRESET) begin
            cap_on = 1'b0;
        end else if (baud_tick) begin
            if (cap_on) begin
                if (cap_len < 16) cap_bits[cap_len] = TXD;
                cap_len++;
                if (!tx_busy) busy_err++;
            end
            if (tx_done) begin
                check("done_inside_frame", cap_on, 1);
                if (cap_on) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        check("frame_bits", cap_bits, exp_q.pop_front());
                        check("frame_len", cap_len, exp_len_q.pop_front());
                        check("frame_busy", busy_err, 0);
                    end
                end
                check("b2b_pop", tx_fifo_pop, TXen && !tx_fifo_empty);
                cap_on = 1'b0;
            end
            if (tx_fifo_pop) begin
                cap_on   = 1'b1;
                cap_len  = 0;
                cap_bits = 16'd0;
                busy_err = 0;
            end
        end
        prev_txd  = TXD;
        prev_tick = baud_tick;
        prev_rst  = PRESET;
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int nt;
        int dn;
        PRESET    = 1'b1;
        baud_tick = 1'b0;
        TXen      = 1'b1;
`ifdef UART_TX_BREAK_EN
        tx_break  = 1'b0;
`endif
        set_cfg(8, 0, 0, 0);
        update_fifo_pins();
        repeat (3) cycle();
        check("rst_txd", TXD, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_pop", tx_fifo_pop, 0);
        PRESET = 1'b0;
        repeat (5) cycle();

        // 8N1, 0xA5
        set_cfg(8, 0, 0, 0);
        push_byte(8'hA5);
        run_idle(16 * 14);

        // 7 bits, even then odd parity, two stop bits, 0x83
        set_cfg(7, 1, 0, 1);
        push_byte(8'h83);
        run_idle(16 * 14);
        set_cfg(7, 1, 1, 1);
        push_byte(8'h83);
        run_idle(16 * 14);

        // Length clamping
        set_cfg(3, 0, 0, 0);
        push_byte(8'hFF);
        run_idle(16 * 14);
        set_cfg(12, 0, 0, 0);
        push_byte(8'hFF);
        run_idle(16 * 14);

        // Back-to-back 8N1: 20 ticks from first pop to second tx_done
        set_cfg(8, 0, 0, 0);
        push_byte(8'h3C);
        push_byte(8'hC3);
        k = 0;
        s_pop = 1'b0;
        while (!s_pop && k < 2000) begin
            cycle();
            k++;
        end
        nt = 0;
        dn = 0;
        while (dn < 2 && k < 2000) begin
            cycle();
            k++;
            if (s_tick) nt++;
            if (s_done) dn++;
        end
        check("b2b_ticks", nt, 20);
        run_idle(16 * 14);

        // Random configurations and data
        for (int i = 0; i < 6; i++) begin
            set_cfg($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            push_byte(8'($urandom_range(0, 255)));
            if (i % 2 == 1) push_byte(8'($urandom_range(0, 255)));
            run_idle(16 * 30);
        end

        // TXen drop and config change mid-frame
        set_cfg(8, 0, 0, 0);
        push_byte(8'h11);
        wait_busy(64);
        TXen = 1'b0;
        set_cfg(6, 1, 1, 1);
        push_byte(8'h2E);
        repeat (16 * 14) cycle();
        check("txen_fifo_kept", fifo_q.size(), 1);
        check("txen_idle", tx_busy, 0);
        TXen = 1'b1;
        run_idle(16 * 14);

        // Reset during data bit 3; the second word goes out after reset
        set_cfg(8, 0, 0, 0);
        push_byte(8'hFF);
        push_byte(8'h5A);
        wait_busy(64);
        repeat (69) cycle();
        PRESET = 1'b1;
        cycle();
        check("midrst_txd", TXD, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_fifo", fifo_q.size(), 1);
        PRESET = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_len_q.pop_front());
        run_idle(16 * 14);

`ifdef UART_TX_BREAK_EN
        begin
            int ticks;
            int low;
            int pops;
            int dones;
            logic mark;
            ticks = 0;
            low = 0;
            pops = 0;
            dones = 0;
            mark = 1'b0;
            k = 0;
            while (!baud_tick) cycle();
            tx_break = 1'b1;
            push_byte(8'h96);
            while (ticks < 16 && k < 1000) begin
                cycle();
                k++;
                if (s_pop) pops++;
                if (s_done) dones++;
                if (s_tick) begin
                    if (ticks >= 1 && ticks <= 14 && !s_txd) low++;
                    if (ticks == 15) mark = s_txd;
                    ticks++;
                    if (ticks == 14) tx_break = 1'b0;
                end
            end
            check("brk_low_ticks", low, 14);
            check("brk_mark", mark, 1);
            check("brk_idle", tx_busy, 0);
            check("brk_pops", pops, 0);
            check("brk_dones", dones, 0);
            run_idle(16 * 14);
        end
`endif

        repeat (20) cycle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
